// File: rtl/irq_arb.sv
// irq_arb: picks one of RST / NMI / NUM_IRQ maskable IRQs at instruction boundaries and holds its vector.
// Latency: one clk from sampled boundary (sync & RDY) to take; vector frozen until ack.
// Backpressure: ack releases the arbiter; optional IRQ_ROUND_ROBIN_EN rotates IRQ priority after each ack.
module irq_arb #(
    parameter int         NUM_IRQ  = 4,
    parameter logic [7:0] VEC_BASE = 8'hF8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               NMI,
    input  logic               I,
    input  logic               sync,
    input  logic               RDY,
    input  logic               ack,
    input  logic               msk_we,
    input  logic [NUM_IRQ-1:0] msk_di,
    output logic               take,
    output logic [7:0]         vec,
    output logic               is_rst,
    output logic               is_nmi,
    output logic [2:0]         irq_id,
    output logic [NUM_IRQ-1:0] msk
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         vec_q, vec_d;
    logic               is_rst_q, is_rst_d;
    logic               is_nmi_q, is_nmi_d;
    logic [2:0]         irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0] msk_q, msk_d;
    logic               nmi_lat_q, nmi_lat_d;
    logic               nmi_prev_q, nmi_prev_d;

    // Requests padded to 8 so a 3-bit channel number indexes them directly.
    logic [7:0]         req8;
    logic               win_found;
    logic [2:0]         win_id;
    logic [7:0]         win_vec;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0]         rr_q, rr_d;
    int                 idx;
`endif

    // Choose the winning enabled IRQ channel and its vector low byte.
    always_comb begin : arbitrate
        req8                = '0;
        req8[NUM_IRQ-1:0]   = IRQ & msk_q;
        win_id              = '0;
`ifdef IRQ_ROUND_ROBIN_EN
        idx = 0;
        // Walk backwards so the smallest offset from rr is assigned last and wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
            if (req8[3'(idx)]) win_id = 3'(idx);
        end
`else
        // Walk backwards so the lowest requesting index is assigned last and wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req8[3'(i)]) win_id = 3'(i);
        end
`endif
        win_found = |req8;
        win_vec   = (win_id == 3'd0) ? 8'hFE : VEC_BASE - {4'b0000, win_id, 1'b0};
    end

    // Next-state and datapath: edge-detect NMI, sample at boundaries, release on ack.
    always_comb begin : next_state
        state_d    = state_q;
        vec_d      = vec_q;
        is_rst_d   = is_rst_q;
        is_nmi_d   = is_nmi_q;
        irq_id_d   = irq_id_q;
        nmi_lat_d  = nmi_lat_q;
        nmi_prev_d = NMI;
        msk_d      = msk_we ? msk_di : msk_q;
`ifdef IRQ_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            ST_RESET: begin
                if (ack) state_d = ST_IDLE;
            end
            ST_PEND: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    if (is_nmi_q) nmi_lat_d = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
                    if (!is_nmi_q && !is_rst_q)
                        rr_d = (irq_id_q == 3'(NUM_IRQ - 1)) ? 3'd0 : irq_id_q + 3'd1;
`endif
                end
            end
            ST_IDLE: begin
                if (sync && RDY) begin
                    if (nmi_lat_q) begin
                        state_d  = ST_PEND;
                        vec_d    = 8'hFA;
                        is_rst_d = 1'b0;
                        is_nmi_d = 1'b1;
                        irq_id_d = 3'd0;
                    end else if (!I && win_found) begin
                        state_d  = ST_PEND;
                        vec_d    = win_vec;
                        is_rst_d = 1'b0;
                        is_nmi_d = 1'b0;
                        irq_id_d = win_id;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
        // A fresh edge beats a same-cycle NMI ack, so back-to-back NMIs are not lost.
        if (NMI && !nmi_prev_q) nmi_lat_d = 1'b1;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_RESET;
            vec_q      <= 8'hFC;
            is_rst_q   <= 1'b1;
            is_nmi_q   <= 1'b0;
            irq_id_q   <= 3'd0;
            msk_q      <= '1;
            nmi_lat_q  <= 1'b0;
            nmi_prev_q <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_q       <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            is_rst_q   <= is_rst_d;
            is_nmi_q   <= is_nmi_d;
            irq_id_q   <= irq_id_d;
            msk_q      <= msk_d;
            nmi_lat_q  <= nmi_lat_d;
            nmi_prev_q <= nmi_prev_d;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_q       <= rr_d;
`endif
        end
    end

    // Outputs: take follows the registered state, the rest come straight from flops.
    always_comb begin : outputs
        take   = (state_q != ST_IDLE);
        vec    = vec_q;
        is_rst = is_rst_q;
        is_nmi = is_nmi_q;
        irq_id = irq_id_q;
        msk    = msk_q;
    end

endmodule

// File: doc/irq_arb.md
Name: irq_arb

Overview:
- Parametrised interrupt arbiter for the microcoded 65C02 core; replaces the fixed single-IRQ/NMI/RST handling around the sequencer.
- Samples reset, an edge-triggered NMI and NUM_IRQ level-sensitive IRQ lines at instruction boundaries (sync), honours the I flag and a per-channel mask, and picks one winner.
- Presents the winner's vector low byte to the address logic and holds it until the sequencer acknowledges the vector fetch.

Parameters:
- NUM_IRQ, 4, number of maskable IRQ channels; legal range 1..8.
- VEC_BASE, 8'hF8, base for extended channel vectors; channel k>=1 uses VEC_BASE - 2*k.

Ports:
- clk  input  1  CPU clock.
- RST  input  1  synchronous active-high reset.
- IRQ  input  NUM_IRQ  level IRQ requests, active high, synchronous to clk.
- NMI  input  1  non-maskable request, rising-edge sensitive.
- I  input  1  CPU interrupt-disable flag.
- sync  input  1  instruction boundary from the sequencer.
- RDY  input  1  CPU ready; sampling happens only when RDY=1.
- ack  input  1  sequencer has fetched the vector; releases the arbiter.
- msk_we  input  1  load enable for the channel mask.
- msk_di  input  NUM_IRQ  new mask value; 1 = channel enabled.
- take  output  1  interrupt pending; sequencer must enter the interrupt sequence.
- vec  output  8  vector low byte; high byte is always FF.
- is_rst  output  1  pending event is reset.
- is_nmi  output  1  pending event is NMI.
- irq_id  output  3  winning IRQ channel; 0 when is_rst or is_nmi is set.
- msk  output  NUM_IRQ  current mask.

Behaviour:
- Reset state (while RST=1 and on the first cycle after it): state=RESET, take=1, vec=FC, is_rst=1, is_nmi=0, irq_id=0, msk all ones, nmi_lat=0, nmi_prev=0.
- States:
  - IDLE: take=0; vec, is_rst, is_nmi and irq_id hold their last values.
  - RESET: take=1, vec=FC.
  - PEND: take=1; outputs are frozen.
- RESET -> IDLE when ack=1.
- PEND -> IDLE when ack=1. ack is ignored in IDLE.
- NMI edge detect runs every cycle, independent of RDY and state:
  - nmi_prev <= NMI.
  - NMI & ~nmi_prev sets nmi_lat.
- In IDLE, when sync=1 and RDY=1, evaluate in priority order, first match wins:
  1. nmi_lat: go to PEND with is_nmi=1, vec=FA.
  2. I=0 and any (IRQ & msk): go to PEND with the winning channel. Channel 0 gives vec=FE; channel k>=1 gives vec=VEC_BASE-2*k (default ch1 F6, ch2 F4, ch3 F2).
  3. Otherwise stay in IDLE.
- Transition to PEND happens on the clk edge where the condition holds. take is registered, so it is high from the next cycle.
- Default channel priority is fixed: lowest index wins.
- A winner is committed once chosen. If IRQ drops or the mask changes while in PEND, vec and irq_id do not change.
- ack of an NMI clears nmi_lat. If a new NMI edge arrives in the same cycle as that ack, set wins and nmi_lat stays 1.
- While nmi_lat=1, further NMI edges are absorbed; at most one NMI is pending.
- RST asserted in any state aborts PEND and returns to RESET next cycle. A latched NMI is discarded.
- msk_we=1 loads msk_di on the next clk edge in any state, and affects arbitration from the following cycle.
- sync=1 with RDY=0: no sampling, state held.
- IRQ bits at indices >= NUM_IRQ do not exist; irq_id upper bits read 0.

Optional Feature:
- Macro IRQ_ROUND_ROBIN_EN.
- Defined: a rotating pointer rr (reset 0) sets the search start.
  - The winner is the first enabled, requesting channel at or after rr, wrapping modulo NUM_IRQ.
  - On ack of an IRQ winner k, rr <= (k+1) mod NUM_IRQ.
  - NMI and RST acks leave rr unchanged.
- Undefined: fixed lowest-index priority; no rr register.

Test Plan:
- Reset/vector: RST=1 for 3 cycles, then 0 -> take=1, vec=FC, is_rst=1 until ack; after ack, take=0 next cycle.
- Priority and masking: IRQ=4'b0110, I=0, msk=F, sync+RDY -> vec=F6, irq_id=1. Repeat with msk=4'b1101 -> vec=F4, irq_id=2. Repeat with I=1 -> take stays 0.
- NMI edge: pulse NMI for 1 cycle while sync=0, then sync -> vec=FA, is_nmi=1. Hold NMI high through ack -> no second NMI. Also: an NMI edge in the same cycle as the NMI ack -> a second NMI is taken at the next sync.
- Commit and RDY: IRQ[0] high, sync=1 with RDY=0 -> take=0. Then RDY=1 -> PEND with vec=FE. Drop IRQ[0] and assert IRQ[3] before ack -> vec stays FE.
- Reset mid-service: in PEND (vec=F2), assert RST for 1 cycle -> next cycle vec=FC, is_rst=1, nmi_lat=0.
- (IRQ_ROUND_ROBIN_EN) IRQ=4'b1111 held, four sync/ack rounds -> irq_id sequence 0, 1, 2, 3, then 0.
